// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//   Round-robin Wishbone arbiter sharing one slave-side bus between
//   NUM_MASTERS masters. Ownership is granted for a whole cycle (held while
//   the owner keeps cyc high), acks/errs are routed to the owner only, and a
//   watchdog forces an err when a strobed access is never terminated.
//
// Ports
//   clk, rst                 clock (rising edge) / asynchronous active-low reset
//   mCyc, mStb, mWe          per-master Wishbone control, one bit per master
//   mAdr, mSel, mDatOut      packed per-master address / byte select / write data
//   mDatIn                   read data broadcast to every master
//   mAck, mErr               per-master termination, only the owner's bit can rise
//   sCyc, sStb, sWe          slave-side control of the granted master
//   sAdr, sSel, sDatOut      slave-side address / byte select / write data
//   sDatIn, sAck, sErr       slave read data and termination
//   grant                    registered one-hot owner, zero when idle/releasing
//   timeoutErr               one-cycle pulse when the watchdog expires
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            mCyc,
  input  logic [NUM_MASTERS-1:0]            mStb,
  input  logic [NUM_MASTERS-1:0]            mWe,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mAdr,
  input  logic [NUM_MASTERS*BUS_WIDTH/8-1:0] mSel,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  mDatOut,
  output logic [BUS_WIDTH-1:0]              mDatIn,
  output logic [NUM_MASTERS-1:0]            mAck,
  output logic [NUM_MASTERS-1:0]            mErr,
  output logic                              sCyc,
  output logic                              sStb,
  output logic                              sWe,
  output logic [ADDR_WIDTH-1:0]             sAdr,
  output logic [BUS_WIDTH/8-1:0]            sSel,
  output logic [BUS_WIDTH-1:0]              sDatOut,
  input  logic [BUS_WIDTH-1:0]              sDatIn,
  input  logic                              sAck,
  input  logic                              sErr,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              timeoutErr
);

  localparam int SEL_W = BUS_WIDTH / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Width 1 keeps the counter legal when the watchdog is disabled.
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       last_q;
  logic [WD_W-1:0]        wd_cnt_q;
  logic                   wd_fire_q;

  logic [IDX_W-1:0]       rr_cand_d;
  logic [IDX_W-1:0]       pick_idx_d;
  logic                   pick_vld_d;
  logic [NUM_MASTERS-1:0] pick_oh_d;
  logic                   wd_run_s;

  // Round-robin pick: scan last+1, last+2, ... and keep the first requester.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = last_q;
    rr_cand_d  = last_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_cand_d  = IDX_W'((int'(last_q) + k) % NUM_MASTERS);
      pick_idx_d = (!pick_vld_d && mCyc[rr_cand_d]) ? rr_cand_d : pick_idx_d;
      pick_vld_d = pick_vld_d | mCyc[rr_cand_d];
    end
    pick_oh_d = pick_vld_d ? (ONE_HOT0 << pick_idx_d) : '0;
  end

  // Ownership FSM: grant in IDLE, hold while owner keeps cyc, one RELEASE gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_d) begin
            grant_q <= pick_oh_d;
            owner_q <= pick_idx_d;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!mCyc[owner_q]) begin
            grant_q <= '0;
            last_q  <= owner_q;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave-side mux: grant_q is zero outside BUSY, so the AND-OR also gates strobes off.
  always_comb begin
    sCyc    = 1'b0;
    sStb    = 1'b0;
    sWe     = 1'b0;
    sAdr    = '0;
    sSel    = '0;
    sDatOut = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sCyc    = sCyc | (mCyc[i] & grant_q[i]);
      sStb    = sStb | (mStb[i] & grant_q[i]);
      sWe     = sWe  | (mWe[i]  & grant_q[i]);
      sAdr    = sAdr    | (mAdr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
      sSel    = sSel    | (mSel[i*SEL_W +: SEL_W]           & {SEL_W{grant_q[i]}});
      sDatOut = sDatOut | (mDatOut[i*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{grant_q[i]}});
    end
  end

  // A strobed access is stalled when neither the slave nor the watchdog terminated it.
  assign wd_run_s = sStb & ~sAck & ~sErr & ~wd_fire_q;

  // Watchdog: count consecutive stalled cycles; fire for one cycle on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      wd_fire_q <= 1'b0;
    end else if ((TIMEOUT_CYCLES == 0) || !wd_run_s) begin
      wd_cnt_q  <= '0;
      wd_fire_q <= 1'b0;
    end else if (wd_cnt_q == WD_LAST) begin
      wd_cnt_q  <= '0;
      wd_fire_q <= 1'b1;
    end else begin
      wd_fire_q <= 1'b0;
      if (wd_cnt_q != WD_MAX) begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
    end
  end

  // Err dominates ack when the slave raises both.
  assign mAck       = grant_q & mStb & {NUM_MASTERS{sAck & ~sErr}};
  assign mErr       = grant_q & mStb & {NUM_MASTERS{sErr | wd_fire_q}};
  assign mDatIn     = sDatIn;
  assign grant      = grant_q;
  assign timeoutErr = wd_fire_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;
  localparam int N  = 2;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam int SW = BW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      mCyc, mStb, mWe, mAck, mErr, grant;
  logic [N*AW-1:0]   mAdr;
  logic [N*SW-1:0]   mSel;
  logic [N*BW-1:0]   mDatOut;
  logic [BW-1:0]     mDatIn, sDatOut, sDatIn;
  logic [AW-1:0]     sAdr;
  logic [SW-1:0]     sSel;
  logic              sCyc, sStb, sWe, sAck, sErr, timeoutErr;

  wb_bus_arbiter #(.NUM_MASTERS(N), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mCyc(mCyc), .mStb(mStb), .mWe(mWe), .mAdr(mAdr), .mSel(mSel),
    .mDatOut(mDatOut), .mDatIn(mDatIn), .mAck(mAck), .mErr(mErr), .sCyc(sCyc), .sStb(sStb),
    .sWe(sWe), .sAdr(sAdr), .sSel(sSel), .sDatOut(sDatOut), .sDatIn(sDatIn), .sAck(sAck),
    .sErr(sErr), .grant(grant), .timeoutErr(timeoutErr));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, whether a gap cycle is pending, who owned last,
  // how many consecutive stalled strobe cycles, and whether the watchdog fires now.
  int own, last, stall;
  bit gap, fire;
  // Stimulus bookkeeping: beats left in the current cycle, cycles left, beats per cycle.
  int beats[N], txns[N], bpt[N];
  bit cool[N];
  int smode, sdelay, swait;
  bit fixed;
  int order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    own = -1; last = N - 1; stall = 0; gap = 0; fire = 0; swait = 0;
    for (int i = 0; i < N; i++) begin beats[i] = 0; txns[i] = 0; cool[i] = 0; end
  endfunction

  function automatic bit owner_stb();
    return (own >= 0) ? mStb[own] : 1'b0;
  endfunction

  function automatic int beats_left();
    int s = 0;
    for (int i = 0; i < N; i++) s += beats[i];
    return s;
  endfunction

  task automatic drive();
    bit strobe;
    for (int i = 0; i < N; i++) begin
      mCyc[i] = (beats[i] > 0) && !cool[i];
      mStb[i] = mCyc[i] && ((own == i) || ($urandom_range(0, 1) == 1));
      mWe[i]  = 1'($urandom_range(0, 1));
      mAdr[i*AW +: AW]    = $urandom;
      mSel[i*SW +: SW]    = SW'($urandom);
      mDatOut[i*BW +: BW] = $urandom;
    end
    if (fixed) begin
      mWe[0] = 1'b1; mAdr[0 +: AW] = 32'h0000_0010; mDatOut[0 +: BW] = 32'hA5A5_A5A5; mSel[0 +: SW] = 4'hF;
    end
    sDatIn = $urandom;
    strobe = owner_stb();
    case (smode)
      0: begin sAck = strobe && (swait >= sdelay); sErr = 1'b0; end
      1: begin sAck = 1'b0; sErr = 1'b0; end
      2: begin sAck = strobe; sErr = strobe; end
      3: begin sAck = ($urandom_range(0, 2) == 0); sErr = ($urandom_range(0, 9) == 0); end
      default: begin sAck = strobe && ($urandom_range(0, 11) == 0); sErr = 1'b0; end
    endcase
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    bit st;
    st = owner_stb();
    eg = (own >= 0) ? (N'(1) << own) : '0;
    chk("grant", grant, eg);
    chk("sCyc", sCyc, (own >= 0) ? mCyc[own] : 1'b0);
    chk("sStb", sStb, st);
    chk("sWe", sWe, (own >= 0) ? mWe[own] : 1'b0);
    chk("sAdr", sAdr, (own >= 0) ? mAdr[own*AW +: AW] : '0);
    chk("sSel", sSel, (own >= 0) ? mSel[own*SW +: SW] : '0);
    chk("sDatOut", sDatOut, (own >= 0) ? mDatOut[own*BW +: BW] : '0);
    chk("mDatIn", mDatIn, sDatIn);
    chk("mAck", mAck, (st && sAck && !sErr) ? eg : '0);
    chk("mErr", mErr, (st && (sErr || fire)) ? eg : '0);
    chk("timeoutErr", timeoutErr, fire);
  endtask

  // Advance the model across one rising edge using the inputs of the cycle just ended.
  task automatic edge_update();
    bit strobe, term, nf;
    strobe = owner_stb();
    term   = strobe && (sAck || sErr || fire);
    if (strobe && !term) swait++; else swait = 0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    if (term) begin
      beats[own]--;
      if (beats[own] == 0) begin
        txns[own]--;
        if (txns[own] > 0) begin beats[own] = bpt[own]; cool[own] = 1; end
      end
    end
    nf = 0;
    if (strobe && !sAck && !sErr && !fire) begin
      stall++;
      if (stall >= TO) begin nf = 1; stall = 0; end
    end else begin
      stall = 0;
    end
    fire = nf;
    if (own >= 0) begin
      if (!mCyc[own]) begin last = own; own = -1; gap = 1; end
    end else if (gap) begin
      gap = 0;
    end else if (|mCyc) begin
      for (int k = 1; k <= N; k++) begin
        if (own < 0 && mCyc[(last + k) % N]) begin
          own = (last + k) % N;
          order.push_back(own);
        end
      end
    end
  endtask

  task automatic step_a(); drive(); #2; check_all(); endtask
  task automatic step_b(); @(posedge clk); edge_update(); #1; endtask
  task automatic idle(input int n); for (int c = 0; c < n; c++) begin step_a(); step_b(); end endtask

  task automatic arm(input int i, input int b, input int t);
    bpt[i] = b; beats[i] = b; txns[i] = t;
  endtask

  task automatic do_reset();
    rst = 1'b0; mCyc = '0; mStb = '0; mWe = '0; mAdr = '0; mSel = '0; mDatOut = '0;
    sDatIn = '0; sAck = 1'b0; sErr = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", grant, '0); chk("rst_sCyc", sCyc, 1'b0); chk("rst_sStb", sStb, 1'b0);
    chk("rst_mAck", mAck, '0); chk("rst_mErr", mErr, '0); chk("rst_timeoutErr", timeoutErr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int rise, te, pulses, acks1, seen;
    fixed = 0; smode = 0; sdelay = 0;
    do_reset();

    // T1: master 0 single write, slave acks two cycles after the strobe rises.
    arm(0, 1, 1); smode = 0; sdelay = 2; fixed = 1;
    step_a(); chk("t1_grant_idle", grant, 2'b00); step_b();
    step_a(); chk("t1_grant", grant, 2'b01); chk("t1_sAdr", sAdr, 32'h10);
    chk("t1_sDat", sDatOut, 32'hA5A5_A5A5); chk("t1_mAck_early", mAck, 2'b00); step_b();
    step_a(); chk("t1_mAck_wait", mAck, 2'b00); step_b();
    step_a(); chk("t1_mAck", mAck, 2'b01); step_b();
    step_a(); step_b();
    step_a(); chk("t1_release", grant, 2'b00); step_b();
    fixed = 0; idle(2);

    // T2: simultaneous requests after reset alternate 0,1,0,1.
    do_reset();
    order.delete(); sdelay = 0; arm(0, 1, 2); arm(1, 1, 2);
    for (int c = 0; c < 80 && beats_left() > 0; c++) begin step_a(); step_b(); end
    chk("t2_drained", beats_left(), 0);
    chk("t2_count", order.size(), 4);
    for (int j = 0; j < 4 && j < order.size(); j++) chk("t2_order", order[j], j % 2);
    idle(3);

    // T3: master 1 holds a 3-beat burst while master 0 waits.
    order.delete(); sdelay = 1; acks1 = 0;
    arm(1, 3, 1); step_a(); step_b();
    arm(0, 1, 1);
    for (int c = 0; c < 80 && beats_left() > 0; c++) begin
      step_a(); if (mAck[1]) acks1++; step_b();
    end
    chk("t3_drained", beats_left(), 0);
    chk("t3_m1_acks", acks1, 3);
    chk("t3_count", order.size(), 2);
    if (order.size() == 2) begin chk("t3_first", order[0], 1); chk("t3_second", order[1], 0); end
    idle(3);

    // T4: slave never answers; watchdog err lands exactly TO cycles after sStb rises.
    smode = 1; arm(0, 1, 1); rise = -1; te = -1; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step_a();
      if (sStb && rise < 0) rise = c;
      if (timeoutErr) begin pulses++; if (te < 0) te = c; chk("t4_mErr", mErr, 2'b01); end
      step_b();
    end
    chk("t4_latency", te - rise, 8);
    chk("t4_pulses", pulses, 1);

    // T5a: ack and err together -> err only.
    smode = 2; arm(0, 1, 1); seen = 0;
    for (int c = 0; c < 10; c++) begin
      step_a();
      if (sStb) begin seen++; chk("t5_mErr", mErr, 2'b01); chk("t5_mAck", mAck, 2'b00); end
      step_b();
    end
    chk("t5_seen", seen, 1);
    idle(2);

    // T5b: asynchronous reset in the middle of a BUSY cycle.
    smode = 1; arm(0, 1, 1);
    step_a(); step_b();
    step_a(); chk("t5_busy", grant, 2'b01);
    rst = 1'b0; #1;
    chk("t5_rst_grant", grant, 2'b00); chk("t5_rst_sCyc", sCyc, 1'b0);
    chk("t5_rst_sStb", sStb, 1'b0); chk("t5_rst_mErr", mErr, 2'b00);
    model_reset();
    @(posedge clk); #1; rst = 1'b1;

    // Random traffic against the model, then a slow slave to exercise the watchdog.
    smode = 3;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1500) smode = 4;
      for (int i = 0; i < N; i++)
        if (beats[i] == 0 && $urandom_range(0, 3) == 0) arm(i, $urandom_range(1, 4), $urandom_range(1, 3));
      step_a(); step_b();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
